// File: rtl/alarm_clock_core.sv
// 24 h clock with alarm: set-mode FSM, field blinking, timed ringing with snooze,
// and a registered seven-segment driver for 4 (hh:mm) or 6 (hh:mm:ss) digits.
module alarm_clock_core #(
    parameter int TICK_DIV       = 50_000_000,
    parameter int SHOW_SECONDS   = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int ALARM_LEDS     = 7,
    parameter int RING_SECS      = 60
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            btn_mode,
    input  logic                            btn_inc,
    input  logic                            btn_snooze,
    output logic [7*(4+2*SHOW_SECONDS)-1:0] seg,
    output logic [ALARM_LEDS-1:0]           alarm_leds,
    output logic                            alarm_active,
    output logic                            sec_tick
);

    localparam int ND  = 4 + 2*SHOW_SECONDS;
    localparam int OFS = 2 - 2*SHOW_SECONDS;
    localparam int PW  = $clog2(TICK_DIV);
    localparam int RW  = $clog2(RING_SECS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);

    typedef enum logic [2:0] {
        RUN,
        SET_HOUR,
        SET_MIN,
        SET_ALM_HOUR,
        SET_ALM_MIN
    } mode_t;

    mode_t mode_reg, mode_next;

    logic [PW-1:0]         pre_reg;
    logic [4:0]            hour_reg;
    logic [5:0]            min_reg;
    logic [5:0]            sec_reg;
    logic [4:0]            alm_hour_reg;
    logic [5:0]            alm_min_reg;
    logic                  sec_tick_reg;
    logic                  ring_reg;
    logic [RW-1:0]         ring_cnt_reg;
    logic [ALARM_LEDS-1:0] leds_reg;
    logic [7*ND-1:0]       seg_reg;
    logic [7*ND-1:0]       seg_next;

    logic pre_wrap, run_tick, leave_set_min, inc_ok, alarm_match;

    function automatic logic [6:0] seg_font(input logic [3:0] d, input logic blank);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        if (blank) p = 7'h00;
        return (SEG_ACTIVE_LOW != 0) ? ~p : p;
    endfunction

    assign pre_wrap      = (pre_reg == PRE_LAST);
    assign run_tick      = (mode_reg == RUN) && pre_wrap;
    assign leave_set_min = (mode_reg == SET_MIN) && btn_mode;
    assign inc_ok        = btn_inc && !btn_mode;
    // Only a freshly advanced time can trigger; setting the time never rings.
    assign alarm_match   = sec_tick_reg && (sec_reg == 6'd0) &&
                           (hour_reg == alm_hour_reg) && (min_reg == alm_min_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mode_reg <= RUN;
        else      mode_reg <= mode_next;
    end

    always_comb begin
        mode_next = mode_reg;
        if (btn_mode) begin
            case (mode_reg)
                RUN:          mode_next = SET_HOUR;
                SET_HOUR:     mode_next = SET_MIN;
                SET_MIN:      mode_next = SET_ALM_HOUR;
                SET_ALM_HOUR: mode_next = SET_ALM_MIN;
                SET_ALM_MIN:  mode_next = RUN;
                default:      mode_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_reg      <= '0;
            hour_reg     <= '0;
            min_reg      <= '0;
            sec_reg      <= '0;
            alm_hour_reg <= '0;
            alm_min_reg  <= '0;
            sec_tick_reg <= 1'b0;
        end else begin
            sec_tick_reg <= run_tick;
            if (leave_set_min || pre_wrap) pre_reg <= '0;
            else                           pre_reg <= pre_reg + 1'b1;

            if (leave_set_min) begin
                sec_reg <= '0;
            end else if (run_tick) begin
                if (sec_reg == 6'd59) begin
                    sec_reg <= '0;
                    if (min_reg == 6'd59) begin
                        min_reg  <= '0;
                        hour_reg <= (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
                    end else begin
                        min_reg <= min_reg + 6'd1;
                    end
                end else begin
                    sec_reg <= sec_reg + 6'd1;
                end
            end

            if (inc_ok) begin
                case (mode_reg)
                    SET_HOUR:     hour_reg     <= (hour_reg == 5'd23)    ? 5'd0 : hour_reg + 5'd1;
                    SET_MIN:      min_reg      <= (min_reg == 6'd59)     ? 6'd0 : min_reg + 6'd1;
                    SET_ALM_HOUR: alm_hour_reg <= (alm_hour_reg == 5'd23) ? 5'd0 : alm_hour_reg + 5'd1;
                    SET_ALM_MIN:  alm_min_reg  <= (alm_min_reg == 6'd59)  ? 6'd0 : alm_min_reg + 6'd1;
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ring_reg     <= 1'b0;
            ring_cnt_reg <= '0;
            leds_reg     <= '0;
        end else if (ring_reg) begin
            if (btn_snooze) begin
                ring_reg <= 1'b0;
                leds_reg <= '0;
            end else if (sec_tick_reg) begin
                if (ring_cnt_reg <= RW'(1)) begin
                    ring_reg     <= 1'b0;
                    ring_cnt_reg <= '0;
                    leds_reg     <= '0;
                end else begin
                    ring_cnt_reg <= ring_cnt_reg - 1'b1;
                    leds_reg     <= {leds_reg[ALARM_LEDS-2:0], leds_reg[ALARM_LEDS-1]};
                end
            end
        end else if (alarm_match) begin
            ring_reg     <= 1'b1;
            ring_cnt_reg <= RW'(RING_SECS);
            leds_reg     <= ALARM_LEDS'(1);
        end
    end

    // Six logical digits (ss, mm, hh, LSD first); 4-digit builds skip the seconds pair.
    logic [3:0] full_val   [6];
    logic       full_blank [6];
    logic       show_alarm, blink_off, blank_h, blank_m;
    logic [4:0] disp_h;
    logic [5:0] disp_m, disp_s;

    always_comb begin
        show_alarm = (mode_reg == SET_ALM_HOUR) || (mode_reg == SET_ALM_MIN);
        blink_off  = (pre_reg >= PRE_HALF);
        blank_h    = blink_off && ((mode_reg == SET_HOUR) || (mode_reg == SET_ALM_HOUR));
        blank_m    = blink_off && ((mode_reg == SET_MIN)  || (mode_reg == SET_ALM_MIN));
        disp_h     = show_alarm ? alm_hour_reg : hour_reg;
        disp_m     = show_alarm ? alm_min_reg  : min_reg;
        disp_s     = show_alarm ? 6'd0         : sec_reg;
        full_val[0]   = 4'(disp_s % 6'd10);
        full_val[1]   = 4'(disp_s / 6'd10);
        full_val[2]   = 4'(disp_m % 6'd10);
        full_val[3]   = 4'(disp_m / 6'd10);
        full_val[4]   = 4'(disp_h % 5'd10);
        full_val[5]   = 4'(disp_h / 5'd10);
        full_blank[0] = 1'b0;
        full_blank[1] = 1'b0;
        full_blank[2] = blank_m;
        full_blank[3] = blank_m;
        full_blank[4] = blank_h;
        full_blank[5] = blank_h;
    end

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_digit
            assign seg_next[7*gi +: 7] = seg_font(full_val[gi+OFS], full_blank[gi+OFS]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) seg_reg <= {ND{seg_font(4'd0, 1'b0)}};
        else      seg_reg <= seg_next;
    end

    assign seg          = seg_reg;
    assign alarm_leds   = leds_reg;
    assign alarm_active = ring_reg;
    assign sec_tick     = sec_tick_reg;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Directed bench for alarm_clock_core: counting, setting, blinking, ringing, snooze, reset.
module tb_alarm_clock_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_snooze = 1'b0;
    logic [41:0] seg;
    logic [6:0]  alarm_leds;
    logic        alarm_active, sec_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int ticks    = 0;

    always #5 clk = ~clk;

    alarm_clock_core #(
        .TICK_DIV(4), .SHOW_SECONDS(1), .SEG_ACTIVE_LOW(1), .ALARM_LEDS(7), .RING_SECS(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_snooze(btn_snooze),
        .seg(seg), .alarm_leds(alarm_leds), .alarm_active(alarm_active), .sec_tick(sec_tick)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Active-low segment pattern for one digit; blank is all segments off.
    function automatic logic [6:0] digit_seg(input int d, input bit blank);
        logic [6:0] f;
        case (d)
            0: f = 7'h3F;  1: f = 7'h06;  2: f = 7'h5B;  3: f = 7'h4F;  4: f = 7'h66;
            5: f = 7'h6D;  6: f = 7'h7D;  7: f = 7'h07;  8: f = 7'h7F;  default: f = 7'h6F;
        endcase
        return blank ? 7'h7F : ~f;
    endfunction

    function automatic logic [63:0] disp(input int h, input int m, input int s,
                                         input bit bh, input bit bm);
        logic [41:0] v;
        v = {digit_seg(h/10, bh), digit_seg(h%10, bh), digit_seg(m/10, bm),
             digit_seg(m%10, bm), digit_seg(s/10, 1'b0), digit_seg(s%10, 1'b0)};
        return 64'(v);
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (sec_tick) ticks++;
        end
    endtask

    task automatic pulse(input bit m, input bit i, input bit s);
        btn_mode = m; btn_inc = i; btn_snooze = s;
        cycles(1);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        #1 rst = 1'b0;
        #3;
        check("rst_seg",    64'(seg), disp(0, 0, 0, 0, 0));
        check("rst_leds",   64'(alarm_leds), 64'd0);
        check("rst_active", 64'(alarm_active), 64'd0);
        check("rst_tick",   64'(sec_tick), 64'd0);
        @(negedge clk) rst = 1'b1;

        // 1: one minute of free running
        ticks = 0;
        cycles(241);
        check("t1_ticks",  64'(ticks), 64'd60);
        check("t1_seg",    64'(seg), disp(0, 1, 0, 0, 0));
        check("t1_digit0", 64'(seg[6:0]), 64'(7'b1000000));

        // 2: set 23:59, alarm 00:02, roll over midnight
        pulse(1, 0, 0);
        repeat (23) pulse(0, 1, 0);
        pulse(1, 0, 0);
        repeat (58) pulse(0, 1, 0);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        repeat (2) pulse(0, 1, 0);
        pulse(1, 0, 0);
        cycles(1);
        check("t2_set_seg", 64'(seg), disp(23, 59, 0, 0, 0));
        ticks = 0;
        cycles(240);
        check("t2_ticks",  64'(ticks), 64'd60);
        check("t2_wrap",   64'(seg), disp(0, 0, 0, 0, 0));
        check("t2_noring", 64'(alarm_active), 64'd0);

        // 3: ring at 00:02:00 for three seconds
        cycles(479);
        check("t3_tick",      64'(sec_tick), 64'd1);
        check("t3_seg",       64'(seg), disp(0, 1, 59, 0, 0));
        check("t3_pre",       64'(alarm_active), 64'd0);
        cycles(1);
        check("t3_active",    64'(alarm_active), 64'd1);
        check("t3_leds0",     64'(alarm_leds), 64'h01);
        cycles(4);
        check("t3_leds1",     64'(alarm_leds), 64'h02);
        cycles(4);
        check("t3_leds2",     64'(alarm_leds), 64'h04);
        cycles(3);
        check("t3_still",     64'(alarm_active), 64'd1);
        cycles(1);
        check("t3_end",       64'(alarm_active), 64'd0);
        check("t3_end_leds",  64'(alarm_leds), 64'd0);

        // 4: alarm 00:03, snooze while ringing, then snooze while idle
        repeat (4) pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        cycles(238);
        check("t4_ring",       64'(alarm_active), 64'd1);
        check("t4_ring_leds",  64'(alarm_leds), 64'h01);
        pulse(0, 0, 1);
        check("t4_snooze",     64'(alarm_active), 64'd0);
        check("t4_snooze_led", 64'(alarm_leds), 64'd0);
        pulse(0, 0, 1);
        check("t4_idle",       64'(alarm_active), 64'd0);
        check("t4_idle_leds",  64'(alarm_leds), 64'd0);

        // 5: minute wrap without carry, mode+inc collision, blinking phases
        pulse(1, 0, 0);
        repeat (5) pulse(0, 1, 0);
        pulse(1, 0, 0);
        repeat (56) pulse(0, 1, 0);
        cycles(1);
        check("t5_blank_m",  64'(seg), disp(5, 59, 1, 0, 1));
        cycles(2);
        check("t5_show_m",   64'(seg), disp(5, 59, 1, 0, 0));
        pulse(0, 1, 0);
        cycles(3);
        check("t5_min_wrap", 64'(seg), disp(5, 0, 1, 0, 0));
        pulse(1, 1, 0);
        cycles(1);
        check("t5_alm_show", 64'(seg), disp(0, 3, 0, 0, 0));
        cycles(2);
        check("t5_alm_bl2",  64'(seg), disp(0, 3, 0, 1, 0));
        cycles(1);
        check("t5_alm_bl3",  64'(seg), disp(0, 3, 0, 1, 0));
        cycles(1);
        check("t5_alm_back", 64'(seg), disp(0, 3, 0, 0, 0));

        // 6: alarm 05:01, enter SET_HOUR while ringing, then asynchronous reset
        repeat (5) pulse(0, 1, 0);
        pulse(1, 0, 0);
        repeat (58) pulse(0, 1, 0);
        pulse(1, 0, 0);
        k = 0;
        while (!alarm_active && k < 400) begin
            cycles(1);
            k++;
        end
        check("t6_ring",     64'(alarm_active), 64'd1);
        pulse(1, 0, 0);
        cycles(6);
        check("t6_set_ring", 64'(alarm_active), 64'd1);
        check("t6_set_leds", 64'(alarm_leds), 64'h01);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_active", 64'(alarm_active), 64'd0);
        check("t6_rst_leds",   64'(alarm_leds), 64'd0);
        check("t6_rst_tick",   64'(sec_tick), 64'd0);
        check("t6_rst_seg",    64'(seg), disp(0, 0, 0, 0, 0));
        @(negedge clk) rst = 1'b1;
        ticks = 0;
        cycles(5);
        check("t6_run_ticks",  64'(ticks), 64'd1);
        check("t6_run_seg",    64'(seg), disp(0, 0, 1, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
